// File: rtl/block_catcher_pkg.sv
// Shared constants, FSM encoding and helpers for the plot arbiter and the game logic.
package block_catcher_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int NREQ     = 3;
  localparam int COLOUR_W = 3;
  localparam int COORD_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } plot_state_e;

  function automatic logic [1:0] onehot_idx(input logic [NREQ-1:0] oh);
    if (oh[2]) return 2'd2;
    if (oh[1]) return 2'd1;
    return 2'd0;
  endfunction
endpackage

// File: rtl/plot_arbiter_if.sv
// Requester/arbiter bundle: rectangle requests in, grant/done and pixel stream out.
interface plot_arbiter_if;
  import block_catcher_pkg::*;

  logic [NREQ-1:0]            req;
  logic [NREQ*COORD_W-1:0]    rect_x;
  logic [NREQ*COORD_W-1:0]    rect_y;
  logic [NREQ*COORD_W-1:0]    rect_w;
  logic [NREQ*COORD_W-1:0]    rect_h;
  logic [NREQ*COLOUR_W-1:0]   rect_colour;
  logic [NREQ-1:0]            grant;
  logic [NREQ-1:0]            done;
  logic                       busy;
  logic [COORD_W-1:0]         x_out;
  logic [COORD_W-1:0]         y_out;
  logic [COLOUR_W-1:0]        colour_out;
  logic                       writeEn;

  modport master (
    output req, rect_x, rect_y, rect_w, rect_h, rect_colour,
    input  grant, done, busy, x_out, y_out, colour_out, writeEn
  );

  modport slave (
    input  req, rect_x, rect_y, rect_w, rect_h, rect_colour,
    output grant, done, busy, x_out, y_out, colour_out, writeEn
  );
endinterface

// File: rtl/rr_arbiter3.sv
// Combinational three-way round-robin: search starts one past the last served requester.
module rr_arbiter3
  import block_catcher_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  output logic [NREQ-1:0] winner
);
  logic [1:0] idx;
  logic       found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = (last == 2'd2) ? 2'd0 : last + 2'd1;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
  end
endmodule

// File: rtl/plot_arbiter.sv
// Grants the shared plot port to one rectangle requester at a time and rasterises
// the latched rectangle one pixel per cycle, clipping off-screen pixels.
module plot_arbiter #(
  parameter int SCREEN_W = block_catcher_pkg::SCREEN_W,
  parameter int SCREEN_H = block_catcher_pkg::SCREEN_H
) (
  input  logic          clk,
  input  logic          reset,
  plot_arbiter_if.slave bus
);
  import block_catcher_pkg::*;

  plot_state_e          state;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      done;
  logic [NREQ-1:0]      winner;
  logic [1:0]           last;
  logic [1:0]           owner;
  logic [1:0]           sel;
  logic [COORD_W-1:0]   ox, oy, w, h, cx, cy;
  logic [COORD_W-1:0]   w_sel, h_sel;
  logic [COLOUR_W-1:0]  col;
  logic [COORD_W:0]     sum_x, sum_y;
  logic                 drawing;

  rr_arbiter3 u_rr (
    .req    (bus.req),
    .last   (last),
    .winner (winner)
  );

  assign sel   = onehot_idx(winner);
  assign w_sel = bus.rect_w[int'(sel)*COORD_W +: COORD_W];
  assign h_sel = bus.rect_h[int'(sel)*COORD_W +: COORD_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      done  <= '0;
      cx    <= '0;
      cy    <= '0;
      last  <= 2'd2;
      owner <= 2'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|bus.req) begin
            grant <= winner;
            owner <= sel;
            ox    <= bus.rect_x[int'(sel)*COORD_W +: COORD_W];
            oy    <= bus.rect_y[int'(sel)*COORD_W +: COORD_W];
            w     <= w_sel;
            h     <= h_sel;
            col   <= bus.rect_colour[int'(sel)*COLOUR_W +: COLOUR_W];
            cx    <= '0;
            cy    <= '0;
            // Empty rectangles skip straight to the completion pulse.
            if (w_sel == '0 || h_sel == '0) begin
              state <= DONE;
              done  <= winner;
            end else begin
              state <= DRAW;
            end
          end
        end
        DRAW: begin
          if (cx == w - 8'd1) begin
            cx <= '0;
            if (cy == h - 8'd1) begin
              state <= DONE;
              done  <= grant;
            end else begin
              cy <= cy + 8'd1;
            end
          end else begin
            cx <= cx + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= '0;
          grant <= '0;
          last  <= owner;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pixel stream is combinational from the latched rectangle and raster counters.
  assign drawing = (state == DRAW);
  assign sum_x   = {1'b0, ox} + {1'b0, cx};
  assign sum_y   = {1'b0, oy} + {1'b0, cy};

  assign bus.grant      = grant;
  assign bus.done       = done;
  assign bus.busy       = (state != IDLE);
  assign bus.x_out      = drawing ? sum_x[COORD_W-1:0] : '0;
  assign bus.y_out      = drawing ? sum_y[COORD_W-1:0] : '0;
  assign bus.colour_out = drawing ? col : '0;
  assign bus.writeEn    = drawing && (sum_x < 9'(SCREEN_W)) && (sum_y < 9'(SCREEN_H));
endmodule

// File: tb/tb_plot_arbiter.sv
// Randomised self-checking bench for plot_arbiter against a rectangle/round-robin model.
module tb_plot_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  plot_arbiter_if bus();
  plot_arbiter #(.SCREEN_W(160), .SCREEN_H(120)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed { logic [7:0] x; logic [7:0] y; logic [2:0] c; } pix_t;

  int total = 0;
  int bad   = 0;
  pix_t obs_q[$];
  pix_t exp_q[$];
  int busy_cyc, done_cyc, grant_err, zero_err, last_we_idx, done_idx, tmo;

  task automatic set_rect(input int i, input logic [7:0] x, y, w, h, input logic [2:0] c);
    bus.rect_x[i*8 +: 8]      = x;
    bus.rect_y[i*8 +: 8]      = y;
    bus.rect_w[i*8 +: 8]      = w;
    bus.rect_h[i*8 +: 8]      = h;
    bus.rect_colour[i*3 +: 3] = c;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference raster: every on-screen pixel of the rectangle, row-major.
  task automatic build_exp(input logic [7:0] x, y, w, h, input logic [2:0] c);
    exp_q.delete();
    for (int r = 0; r < int'(h); r++)
      for (int q = 0; q < int'(w); q++)
        if (int'(x) + q < 160 && int'(y) + r < 120)
          exp_q.push_back(pix_t'{8'(int'(x) + q), 8'(int'(y) + r), c});
  endtask

  function automatic int pix_diff();
    int d;
    d = (obs_q.size() > exp_q.size()) ? obs_q.size() - exp_q.size() : exp_q.size() - obs_q.size();
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++)
      if (obs_q[k] !== exp_q[k]) d++;
    return d;
  endfunction

  function automatic int rr_pick(input logic [2:0] m, input int last);
    for (int k = 1; k <= 3; k++)
      if (m[(last + k) % 3]) return (last + k) % 3;
    return -1;
  endfunction

  // Drives one request alone and records everything the DUT does until after done.
  task automatic run_one(input int i, input logic [7:0] x, y, w, h, input logic [2:0] c);
    int cyc;
    bit finish_next;
    obs_q.delete();
    busy_cyc = 0; done_cyc = 0; grant_err = 0; zero_err = 0;
    last_we_idx = -1; done_idx = -1; tmo = 0; cyc = 0; finish_next = 0;
    @(negedge clk);
    set_rect(i, x, y, w, h, c);
    bus.req[i] = 1'b1;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) begin
        busy_cyc++;
        if (bus.grant !== 3'(1 << i)) grant_err++;
        set_rect(i, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 3'($urandom));
      end
      if (bus.writeEn) begin
        obs_q.push_back(pix_t'{bus.x_out, bus.y_out, bus.colour_out});
        last_we_idx = cyc;
      end
      if (bus.done !== 3'b000) begin
        done_cyc++;
        done_idx = cyc;
        if (bus.done !== 3'(1 << i)) grant_err++;
      end
      if ((bus.done !== 3'b000 || !bus.busy) &&
          (bus.writeEn !== 1'b0 || bus.x_out !== 8'd0 || bus.y_out !== 8'd0 || bus.colour_out !== 3'd0))
        zero_err++;
      if (finish_next) break;
      if (bus.done[i]) begin bus.req[i] = 1'b0; finish_next = 1; end
      if (cyc > int'(w) * int'(h) + 20) begin tmo = 1; bus.req[i] = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.grant !== 3'b000) begin bad++; $display("FAIL reset_grant got=%b exp=000", bus.grant); end
    total++; if (bus.done !== 3'b000) begin bad++; $display("FAIL reset_done got=%b exp=000", bus.done); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.writeEn !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", bus.writeEn); end
    total++; if ({bus.x_out, bus.y_out, bus.colour_out} !== 19'd0) begin
      bad++; $display("FAIL reset_pix got=%0d,%0d,%0d exp=0,0,0", bus.x_out, bus.y_out, bus.colour_out); end
  endtask

  task automatic test_background();
    do_reset();
    run_one(0, 8'd0, 8'd0, 8'd160, 8'd120, 3'b000);
    build_exp(8'd0, 8'd0, 8'd160, 8'd120, 3'b000);
    total++; if (tmo != 0) begin bad++; $display("FAIL bg_timeout got=%0d exp=0", tmo); end
    total++; if (obs_q.size() != 19200) begin bad++; $display("FAIL bg_writes got=%0d exp=19200", obs_q.size()); end
    total++; if (pix_diff() != 0) begin bad++; $display("FAIL bg_pixels diffs=%0d exp=0", pix_diff()); end
    total++; if (done_idx != last_we_idx + 1) begin
      bad++; $display("FAIL bg_done_latency got=%0d exp=%0d", done_idx, last_we_idx + 1); end
    total++; if (done_cyc != 1 || grant_err != 0) begin
      bad++; $display("FAIL bg_done_grant done_cyc=%0d grant_err=%0d exp=1,0", done_cyc, grant_err); end
  endtask

  task automatic test_paddle();
    run_one(1, 8'd72, 8'd110, 8'd4, 8'd2, 3'b101);
    build_exp(8'd72, 8'd110, 8'd4, 8'd2, 3'b101);
    total++; if (pix_diff() != 0 || obs_q.size() != 8) begin
      bad++; $display("FAIL paddle_pixels got_n=%0d diffs=%0d exp_n=8", obs_q.size(), pix_diff()); end
    total++; if (busy_cyc != 9) begin bad++; $display("FAIL paddle_busy got=%0d exp=9", busy_cyc); end
    total++; if (done_cyc != 1 || grant_err != 0 || zero_err != 0) begin
      bad++; $display("FAIL paddle_ctrl done=%0d gerr=%0d zerr=%0d exp=1,0,0", done_cyc, grant_err, zero_err); end
  endtask

  task automatic test_ball_clip();
    run_one(2, 8'd158, 8'd118, 8'd3, 8'd3, 3'b110);
    build_exp(8'd158, 8'd118, 8'd3, 8'd3, 3'b110);
    total++; if (pix_diff() != 0 || obs_q.size() != 4) begin
      bad++; $display("FAIL ball_pixels got_n=%0d diffs=%0d exp_n=4", obs_q.size(), pix_diff()); end
    total++; if (busy_cyc != 10) begin bad++; $display("FAIL ball_busy got=%0d exp=10", busy_cyc); end
  endtask

  task automatic test_zero_size();
    run_one(1, 8'd20, 8'd20, 8'd0, 8'd5, 3'b011);
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL zero_w_writes got=%0d exp=0", obs_q.size()); end
    total++; if (done_idx != 1 || busy_cyc != 1 || grant_err != 0) begin
      bad++; $display("FAIL zero_w_done idx=%0d busy=%0d gerr=%0d exp=1,1,0", done_idx, busy_cyc, grant_err); end
    run_one(0, 8'd5, 8'd5, 8'd7, 8'd0, 3'b001);
    total++; if (obs_q.size() != 0 || done_idx != 1) begin
      bad++; $display("FAIL zero_h got_writes=%0d done_idx=%0d exp=0,1", obs_q.size(), done_idx); end
  endtask

  task automatic test_random_rects();
    for (int n = 0; n < 10; n++) begin
      int i;
      logic [7:0] x, y, w, h;
      logic [2:0] c;
      i = $urandom_range(0, 2);
      x = 8'($urandom); y = 8'($urandom);
      if (n % 2 == 0) begin x = 8'($urandom_range(150, 165)); y = 8'($urandom_range(110, 125)); end
      w = 8'($urandom_range(0, 10)); h = 8'($urandom_range(0, 10)); c = 3'($urandom);
      run_one(i, x, y, w, h, c);
      build_exp(x, y, w, h, c);
      total++; if (pix_diff() != 0) begin
        bad++; $display("FAIL rand_pixels n=%0d rect=%0d,%0d,%0dx%0d got_n=%0d exp_n=%0d", n, x, y, w, h, obs_q.size(), exp_q.size()); end
      total++; if (busy_cyc != int'(w) * int'(h) + 1 || done_cyc != 1 || grant_err != 0 || zero_err != 0) begin
        bad++; $display("FAIL rand_ctrl n=%0d busy=%0d exp=%0d done=%0d gerr=%0d zerr=%0d", n, busy_cyc, int'(w) * int'(h) + 1, done_cyc, grant_err, zero_err); end
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] got[4];
    logic [2:0] rereq;
    int n, cyc, last;
    do_reset();
    for (int i = 0; i < 3; i++) set_rect(i, 8'(10 * i), 8'd3, 8'd1, 8'd1, 3'(i));
    n = 0; cyc = 0; rereq = '0; last = 2;
    @(negedge clk);
    bus.req = 3'b111;
    while (n < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus.req = bus.req | rereq;
      rereq = '0;
      if (bus.done !== 3'b000) begin
        got[n] = bus.grant;
        n++;
        bus.req = bus.req & ~bus.done;
        rereq = bus.done;
      end
    end
    bus.req = '0;
    repeat (3) @(negedge clk);
    total++; if (n != 4) begin bad++; $display("FAIL rr_timeout got=%0d exp=4", n); end
    for (int k = 0; k < n; k++) begin
      int p;
      p = rr_pick(3'b111, last);
      total++; if (got[k] !== 3'(1 << p)) begin bad++; $display("FAIL rr_order k=%0d got=%b exp=%b", k, got[k], 3'(1 << p)); end
      last = p;
    end
  endtask

  task automatic test_rr_random();
    int last, p, cyc;
    logic [2:0] mask, g;
    do_reset();
    for (int i = 0; i < 3; i++) set_rect(i, 8'd1, 8'd1, 8'd1, 8'd1, 3'd7);
    last = 2;
    for (int r = 0; r < 8; r++) begin
      mask = 3'($urandom_range(1, 7));
      bus.req = mask;
      @(negedge clk);
      g = bus.grant;
      p = rr_pick(mask, last);
      total++; if (g !== 3'(1 << p)) begin
        bad++; $display("FAIL rr_rand r=%0d mask=%b last=%0d got=%b exp=%b", r, mask, last, g, 3'(1 << p)); end
      cyc = 0;
      while (bus.done === 3'b000 && cyc < 10) begin @(negedge clk); cyc++; end
      bus.req = '0;
      @(negedge clk);
      last = p;
    end
  endtask

  task automatic test_reset_during_draw();
    int k, cyc, seen_done;
    do_reset();
    set_rect(0, 8'd10, 8'd10, 8'd4, 8'd4, 3'b011);
    bus.req = 3'b001;
    k = 0; cyc = 0; seen_done = 0;
    while (k < 5 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) k++;
      if (bus.done !== 3'b000) seen_done++;
    end
    reset = 1'b1;
    bus.req = '0;
    @(negedge clk);
    total++; if (k != 5) begin bad++; $display("FAIL rst_draw_reach got=%0d exp=5", k); end
    total++; if (bus.busy !== 1'b0 || bus.grant !== 3'b000 || bus.writeEn !== 1'b0) begin
      bad++; $display("FAIL rst_draw_state busy=%b grant=%b we=%b exp=0,000,0", bus.busy, bus.grant, bus.writeEn); end
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done !== 3'b000 || bus.busy !== 1'b0) seen_done++;
    end
    total++; if (seen_done != 0) begin bad++; $display("FAIL rst_draw_no_done got=%0d exp=0", seen_done); end
  endtask

  initial begin
    reset = 1'b1;
    bus.req = '0;
    bus.rect_x = '0; bus.rect_y = '0; bus.rect_w = '0; bus.rect_h = '0; bus.rect_colour = '0;
    test_reset();
    test_background();
    test_paddle();
    test_ball_clip();
    test_zero_size();
    test_random_rects();
    test_round_robin();
    test_rr_random();
    test_reset_during_draw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/plot_arbiter.md
PLOT_ARBITER -- requirements
Module: plot_arbiter

Interface
REQ-001 Parameter SCREEN_W, 160, visible pixel columns; pixels at x >= SCREEN_W SHALL be clipped.
REQ-002 Parameter SCREEN_H, 120, visible pixel rows; pixels at y >= SCREEN_H SHALL be clipped.
REQ-003 clk  in  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req  in  3  per-requester rectangle draw request: bit 0 background, bit 1 paddle, bit 2 ball.
REQ-006 rect_x  in  24  packed 8-bit origin x per requester; requester i uses bits [8i+7:8i].
REQ-007 rect_y  in  24  packed 8-bit origin y per requester.
REQ-008 rect_w  in  24  packed 8-bit width per requester.
REQ-009 rect_h  in  24  packed 8-bit height per requester.
REQ-010 rect_colour  in  9  packed 3-bit colour per requester.
REQ-011 grant  out  3  one-hot owner of the plot port; all zero when idle.
REQ-012 done  out  3  one-cycle pulse to the owner when its rectangle completes.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 x_out, y_out  out  8 each  pixel coordinate to vga_adapter.
REQ-015 colour_out  out  3  pixel colour to vga_adapter.
REQ-016 writeEn  out  1  pixel write strobe to vga_adapter.

Function
REQ-017 The FSM SHALL have three states: IDLE, DRAW and DONE.
REQ-018 IDLE: when req is nonzero, the block SHALL pick one winner round-robin, latch that requester's x, y, w, h and colour, set grant to the winner one-hot and reset counters cx and cy to 0, all on the same edge.
REQ-019 Round-robin priority SHALL start at (last served + 1) mod 3.
- last served is updated in DONE.
REQ-020 If the latched w or h is 0, IDLE SHALL go to DONE, otherwise to DRAW.
- A zero-size rectangle produces no writeEn.
REQ-021 DRAW SHALL emit one pixel per cycle in row-major order: cx runs 0..w-1 and wraps to 0 with cy+1; the last pixel is cx=w-1, cy=h-1.
- DRAW lasts exactly w*h cycles.
REQ-022 During DRAW, pixel outputs SHALL be combinational from the latched registers:
- x_out = ox+cx, y_out = oy+cy, both truncated to 8 bits.
- colour_out = latched colour.
REQ-023 writeEn SHALL be 1 in DRAW only when the 9-bit sums satisfy ox+cx < SCREEN_W and oy+cy < SCREEN_H.
- Clipped pixels still consume their cycle.
REQ-024 After the last pixel, the FSM SHALL enter DONE for exactly one cycle.
- In DONE: done[winner]=1, grant is held, writeEn=0.
- On leaving DONE: grant is cleared, last served is set to the winner, the FSM returns to IDLE.
REQ-025 A requester SHALL drop req on the edge where its done is sampled high.
- Any req seen in IDLE is a new request.
- A req change during DRAW or DONE SHALL be ignored.
REQ-026 Requester rect_* inputs SHALL be sampled only on the grant edge.
- Later changes SHALL NOT affect the rectangle in progress.
REQ-027 Outside DRAW: writeEn=0, x_out=0, y_out=0, colour_out=0.
REQ-028 When all three requests arrive together from reset, the grant order SHALL be 0, 1, 2.
- This assumes each requester re-asserts req after its done.

Reset
REQ-029 On reset=1 at a clock edge, the following SHALL take effect regardless of state:
- state=IDLE, grant=0, done=0, busy=0, writeEn=0, x_out=y_out=colour_out=0.
- cx=cy=0, last served=2.
REQ-030 Reset during DRAW SHALL abandon the rectangle with no done pulse.

Structure
REQ-031 Package block_catcher_pkg SHALL hold the following, shared with game_module:
- SCREEN_W, SCREEN_H and NREQ=3.
- The COLOUR_W=3 width.
- The FSM state encoding.
REQ-032 Winner selection SHALL live in sub-module rr_arbiter3 (inputs req and last; output one-hot winner), which is purely combinational.

Verification
REQ-033 Background 160x120 at (0,0), colour 000, requested alone -> 19200 writeEn cycles; first pixel (0,0), last (159,119); done[0] exactly one cycle later.
REQ-034 Paddle 4x2 at (72,110), colour 101 -> 8 writes in order (72..75,110) then (72..75,111); busy high for 9 cycles in total.
REQ-035 Ball 3x3 at (158,118) -> 9 DRAW cycles; writeEn only at (158,118), (159,118), (158,119), (159,119).
REQ-036 req=111 from reset, each requester re-requesting after its done -> grant order 001, 010, 100, 001.
REQ-037 req[1] with w=0 -> grant then done[1] on the next cycle; writeEn never asserted.
REQ-038 reset asserted at the 5th DRAW cycle of a 4x4 rectangle -> next cycle IDLE, grant=0, writeEn=0, no done pulse.
